// File: rtl/rv32i_lsu.sv
// MEM-stage load/store unit: request/ack data port, byte-lane steering, load extension, WB register.
// Optional LSU_MISALIGN_TRAP_EN: misaligned H/W accesses are trapped (lsu_misalign) instead of force-aligned.
module rv32i_lsu #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid_in,
   input  logic [31:0] pc_in,
   input  logic [31:0] iw_in,
   input  logic [31:0] alu_in,
   input  logic [31:0] rs2_data_in,
   input  logic        wb_en_in,
   input  logic [4:0]  wb_reg_in,
   output logic        stall_out,
   output logic        d_req,
   output logic        d_we,
   output logic [29:0] d_addr,
   output logic [3:0]  d_be,
   output logic [31:0] d_wdata,
   input  logic        d_ack,
   input  logic [31:0] d_rdata,
   output logic        valid_out,
   output logic [31:0] pc_out,
   output logic [31:0] iw_out,
   output logic        wb_en_out,
   output logic [4:0]  wb_reg_out,
   output logic [31:0] wb_data_out,
   output logic        df_mem_enable,
   output logic [4:0]  df_mem_reg,
   output logic [31:0] df_mem_data,
   output logic        lsu_err
`ifdef LSU_MISALIGN_TRAP_EN
   ,
   output logic        lsu_misalign
`endif
);

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam int         CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} size_t;
   typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

   state_t state_reg, state_next;

   logic       is_load, is_store, is_mem;
   logic [2:0] funct3;
   size_t      size;
   logic [1:0] addr_lo;
   logic [3:0] be_calc;
   logic [31:0] wdata_calc;

   logic        start_access, ack_retire, timeout_abort, timeout_hit;
   logic [CNT_W-1:0] timeout_cnt_reg;

   logic        acc_load_reg, acc_unsigned_reg, acc_wb_en_reg;
   size_t       acc_size_reg;
   logic [1:0]  acc_addr_lo_reg;
   logic [4:0]  acc_wb_reg_reg;
   logic [31:0] acc_pc_reg, acc_iw_reg;

   logic [7:0]  rd_byte [4];
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;
   logic [31:0] load_data;

`ifdef LSU_MISALIGN_TRAP_EN
   logic misaligned, trap_retire;
`endif

   // Decode of the EX slot
   assign funct3   = iw_in[14:12];
   assign is_load  = (iw_in[6:0] == OP_LOAD);
   assign is_store = (iw_in[6:0] == OP_STORE);
   assign is_mem   = is_load | is_store;

   always_comb begin
      case (funct3[1:0])
         2'b00:   size = SZ_B;
         2'b01:   size = SZ_H;
         default: size = SZ_W;
      endcase
   end

   // Lane offset after forced alignment; H keeps a[1], W always lane 0
   always_comb begin
      case (size)
         SZ_B:    addr_lo = alu_in[1:0];
         SZ_H:    addr_lo = {alu_in[1], 1'b0};
         default: addr_lo = 2'b00;
      endcase
   end

`ifdef LSU_MISALIGN_TRAP_EN
   assign misaligned = ((size == SZ_H) && alu_in[0]) ||
                       ((size == SZ_W) && (alu_in[1:0] != 2'b00));
`endif

   always_comb begin
      case (size)
         SZ_B: begin
            be_calc    = 4'b0001 << addr_lo;
            wdata_calc = {4{rs2_data_in[7:0]}};
         end
         SZ_H: begin
            be_calc    = 4'b0011 << addr_lo;
            wdata_calc = {2{rs2_data_in[15:0]}};
         end
         default: begin
            be_calc    = 4'b1111;
            wdata_calc = rs2_data_in;
         end
      endcase
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign rd_byte[gi] = d_rdata[8*gi +: 8];
      end
   endgenerate

   assign sel_byte = rd_byte[acc_addr_lo_reg];
   assign sel_half = acc_addr_lo_reg[1] ? d_rdata[31:16] : d_rdata[15:0];

   always_comb begin
      case (acc_size_reg)
         SZ_B:    load_data = acc_unsigned_reg ? {24'd0, sel_byte}
                                               : {{24{sel_byte[7]}}, sel_byte};
         SZ_H:    load_data = acc_unsigned_reg ? {16'd0, sel_half}
                                               : {{16{sel_half[15]}}, sel_half};
         default: load_data = d_rdata;
      endcase
   end

   assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                        (timeout_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_next    = state_reg;
      start_access  = 1'b0;
      ack_retire    = 1'b0;
      timeout_abort = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      trap_retire   = 1'b0;
`endif
      case (state_reg)
         IDLE: begin
            if (valid_in && is_mem) begin
`ifdef LSU_MISALIGN_TRAP_EN
               if (misaligned) begin
                  trap_retire = 1'b1;
               end else
`endif
               begin
                  start_access = 1'b1;
                  state_next   = ACCESS;
               end
            end
         end
         ACCESS: begin
            if (d_ack) begin
               ack_retire = 1'b1;
               state_next = IDLE;
            end else if (timeout_hit) begin
               timeout_abort = 1'b1;
               state_next    = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   assign stall_out = (state_reg != IDLE);

   always_ff @(posedge clk) begin
      if (!reset) begin
         d_req            <= 1'b0;
         d_we             <= 1'b0;
         d_addr           <= '0;
         d_be             <= '0;
         d_wdata          <= '0;
         valid_out        <= 1'b0;
         pc_out           <= '0;
         iw_out           <= '0;
         wb_en_out        <= 1'b0;
         wb_reg_out       <= '0;
         wb_data_out      <= '0;
         lsu_err          <= 1'b0;
         timeout_cnt_reg  <= '0;
         acc_load_reg     <= 1'b0;
         acc_unsigned_reg <= 1'b0;
         acc_wb_en_reg    <= 1'b0;
         acc_size_reg     <= SZ_B;
         acc_addr_lo_reg  <= '0;
         acc_wb_reg_reg   <= '0;
         acc_pc_reg       <= '0;
         acc_iw_reg       <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
         lsu_misalign     <= 1'b0;
`endif
      end else begin
         lsu_err <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
         lsu_misalign <= 1'b0;
`endif
         if (start_access) begin
            d_req            <= 1'b1;
            d_we             <= is_store;
            d_addr           <= alu_in[31:2];
            d_be             <= be_calc;
            d_wdata          <= wdata_calc;
            valid_out        <= 1'b0;
            wb_en_out        <= 1'b0;
            timeout_cnt_reg  <= '0;
            acc_load_reg     <= is_load;
            acc_unsigned_reg <= funct3[2];
            acc_wb_en_reg    <= wb_en_in;
            acc_size_reg     <= size;
            acc_addr_lo_reg  <= addr_lo;
            acc_wb_reg_reg   <= wb_reg_in;
            acc_pc_reg       <= pc_in;
            acc_iw_reg       <= iw_in;
         end else if (ack_retire) begin
            d_req       <= 1'b0;
            valid_out   <= 1'b1;
            pc_out      <= acc_pc_reg;
            iw_out      <= acc_iw_reg;
            wb_reg_out  <= acc_wb_reg_reg;
            wb_en_out   <= acc_load_reg & acc_wb_en_reg & (acc_wb_reg_reg != 5'd0);
            wb_data_out <= acc_load_reg ? load_data : 32'd0;
         end else if (timeout_abort) begin
            // Retire the slot without writing back so the pipeline can move on
            d_req       <= 1'b0;
            lsu_err     <= 1'b1;
            valid_out   <= 1'b1;
            pc_out      <= acc_pc_reg;
            iw_out      <= acc_iw_reg;
            wb_reg_out  <= acc_wb_reg_reg;
            wb_en_out   <= 1'b0;
            wb_data_out <= '0;
         end
`ifdef LSU_MISALIGN_TRAP_EN
         else if (trap_retire) begin
            lsu_misalign <= 1'b1;
            valid_out    <= 1'b1;
            pc_out       <= pc_in;
            iw_out       <= iw_in;
            wb_reg_out   <= wb_reg_in;
            wb_en_out    <= 1'b0;
            wb_data_out  <= alu_in;
         end
`endif
         else if (state_reg == ACCESS) begin
            timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
            valid_out       <= 1'b0;
            wb_en_out       <= 1'b0;
         end else begin
            valid_out   <= valid_in;
            pc_out      <= pc_in;
            iw_out      <= iw_in;
            wb_en_out   <= valid_in & wb_en_in;
            wb_reg_out  <= wb_reg_in;
            wb_data_out <= alu_in;
         end
      end
   end

   assign df_mem_enable = wb_en_out & valid_out;
   assign df_mem_reg    = wb_reg_out;
   assign df_mem_data   = wb_data_out;

endmodule

// File: tb/tb_rv32i_lsu.sv
// Directed bench for rv32i_lsu: pass-through, loads/stores, lane steering, timeout and reset abort.
module tb_rv32i_lsu;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_in;
   logic [31:0] pc_in, iw_in, alu_in, rs2_data_in;
   logic        wb_en_in;
   logic [4:0]  wb_reg_in;
   logic        stall_out, d_req, d_we, d_ack;
   logic [29:0] d_addr;
   logic [3:0]  d_be;
   logic [31:0] d_wdata, d_rdata;
   logic        valid_out, wb_en_out, df_mem_enable, lsu_err;
   logic [31:0] pc_out, iw_out, wb_data_out, df_mem_data;
   logic [4:0]  wb_reg_out, df_mem_reg;
`ifdef LSU_MISALIGN_TRAP_EN
   logic        lsu_misalign;
`endif

   int n_cmp = 0;
   int n_err = 0;

   logic        cap_req, cap_we;
   logic [29:0] cap_addr;
   logic [3:0]  cap_be;
   logic [31:0] cap_wdata;
   int          stall_cycles;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_ALU   = 7'b0110011;

   rv32i_lsu #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset(reset), .valid_in(valid_in), .pc_in(pc_in), .iw_in(iw_in),
      .alu_in(alu_in), .rs2_data_in(rs2_data_in), .wb_en_in(wb_en_in), .wb_reg_in(wb_reg_in),
      .stall_out(stall_out), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be),
      .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata), .valid_out(valid_out),
      .pc_out(pc_out), .iw_out(iw_out), .wb_en_out(wb_en_out), .wb_reg_out(wb_reg_out),
      .wb_data_out(wb_data_out), .df_mem_enable(df_mem_enable), .df_mem_reg(df_mem_reg),
      .df_mem_data(df_mem_data), .lsu_err(lsu_err)
`ifdef LSU_MISALIGN_TRAP_EN
      , .lsu_misalign(lsu_misalign)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk_iw(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd);
      return {17'd0, f3, rd, op};
   endfunction

   // Issue one memory instruction, ack after 'waits' stalled cycles, leave the slot empty afterwards
   task automatic mem_op(input logic [31:0] iw, input logic [31:0] a, input logic [31:0] rs2,
                         input logic [31:0] rdata, input int waits);
      valid_in    = 1'b1;
      iw_in       = iw;
      alu_in      = a;
      rs2_data_in = rs2;
      wb_en_in    = 1'b1;
      wb_reg_in   = iw[11:7];
      pc_in       = pc_in + 32'd4;
      tick();
      cap_req      = d_req;
      cap_we       = d_we;
      cap_addr     = d_addr;
      cap_be       = d_be;
      cap_wdata    = d_wdata;
      stall_cycles = 0;
      for (int i = 0; i < waits; i++) begin
         if (stall_out) stall_cycles++;
         tick();
      end
      d_ack   = 1'b1;
      d_rdata = rdata;
      if (stall_out) stall_cycles++;
      tick();
      d_ack    = 1'b0;
      d_rdata  = 32'd0;
      valid_in = 1'b0;
      $display("mem_op iw=%h a=%h req=%0b we=%0b addr=%h be=%b wdata=%h -> valid=%0b wb_en=%0b rd=%0d data=%h stalls=%0d",
               iw, a, cap_req, cap_we, cap_addr, cap_be, cap_wdata, valid_out, wb_en_out,
               wb_reg_out, wb_data_out, stall_cycles);
   endtask

   initial begin
      reset = 1'b0; valid_in = 1'b0; pc_in = 32'h0000_1000; iw_in = '0; alu_in = '0;
      rs2_data_in = '0; wb_en_in = 1'b0; wb_reg_in = '0; d_ack = 1'b0; d_rdata = '0;
      tick();
      tick();
      check("rst_d_req", d_req, 0);
      check("rst_valid_out", valid_out, 0);
      check("rst_stall", stall_out, 0);
      check("rst_lsu_err", lsu_err, 0);
      check("rst_d_addr", d_addr, 0);
      check("rst_wb_data", wb_data_out, 0);
      $display("reset: d_req=%0b valid_out=%0b stall=%0b", d_req, valid_out, stall_out);

      // ALU pass-through
      reset = 1'b1; valid_in = 1'b1; iw_in = mk_iw(OP_ALU, 3'd0, 5'd3); alu_in = 32'h55;
      wb_en_in = 1'b1; wb_reg_in = 5'd3;
      check("add_stall_pre", stall_out, 0);
      tick();
      valid_in = 1'b0;
      check("add_valid", valid_out, 1);
      check("add_wb_data", wb_data_out, 32'h55);
      check("add_df_en", df_mem_enable, 1);
      check("add_df_reg", df_mem_reg, 3);
      check("add_df_data", df_mem_data, 32'h55);
      check("add_pc", pc_out, 32'h1000);
      check("add_stall_post", stall_out, 0);
      $display("add: valid=%0b data=%h df_en=%0b", valid_out, wb_data_out, df_mem_enable);
      tick();
      check("idle_valid", valid_out, 0);

      // LW x5, 2 wait cycles
      mem_op(mk_iw(OP_LOAD, 3'd2, 5'd5), 32'h100, 32'd0, 32'hDEAD_BEEF, 2);
      check("lw_req", cap_req, 1);
      check("lw_we", cap_we, 0);
      check("lw_addr", cap_addr, 32'h40);
      check("lw_be", cap_be, 4'b1111);
      check("lw_stalls", stall_cycles, 3);
      check("lw_valid", valid_out, 1);
      check("lw_data", wb_data_out, 32'hDEAD_BEEF);
      check("lw_reg", wb_reg_out, 5);
      check("lw_wb_en", wb_en_out, 1);
      check("lw_pc", pc_out, 32'h1004);
      check("lw_req_drop", d_req, 0);
      check("lw_stall_drop", stall_out, 0);

      mem_op(mk_iw(OP_LOAD, 3'd0, 5'd6), 32'h103, 32'd0, 32'h80FF_0000, 0);
      check("lb_be", cap_be, 4'b1000);
      check("lb_data", wb_data_out, 32'hFFFF_FF80);
      mem_op(mk_iw(OP_LOAD, 3'd4, 5'd7), 32'h103, 32'd0, 32'h80FF_0000, 1);
      check("lbu_data", wb_data_out, 32'h0000_0080);
      mem_op(mk_iw(OP_LOAD, 3'd0, 5'd8), 32'h101, 32'd0, 32'h0000_7F00, 0);
      check("lb1_be", cap_be, 4'b0010);
      check("lb1_data", wb_data_out, 32'h0000_007F);
      mem_op(mk_iw(OP_LOAD, 3'd1, 5'd9), 32'h102, 32'd0, 32'h8001_1234, 0);
      check("lh_be", cap_be, 4'b1100);
      check("lh_data", wb_data_out, 32'hFFFF_8001);
      mem_op(mk_iw(OP_LOAD, 3'd5, 5'd10), 32'h100, 32'd0, 32'h8001_9234, 0);
      check("lhu_be", cap_be, 4'b0011);
      check("lhu_data", wb_data_out, 32'h0000_9234);

      // Stores
      mem_op(mk_iw(OP_STORE, 3'd1, 5'd0), 32'h22, 32'h1234_ABCD, 32'd0, 1);
      check("sh_we", cap_we, 1);
      check("sh_addr", cap_addr, 32'h8);
      check("sh_be", cap_be, 4'b1100);
      check("sh_wdata", cap_wdata, 32'hABCD_ABCD);
      check("sh_valid", valid_out, 1);
      check("sh_wb_en", wb_en_out, 0);
      mem_op(mk_iw(OP_STORE, 3'd0, 5'd0), 32'h21, 32'h0000_00A5, 32'd0, 0);
      check("sb_be", cap_be, 4'b0010);
      check("sb_wdata", cap_wdata, 32'hA5A5_A5A5);
      mem_op(mk_iw(OP_STORE, 3'd2, 5'd0), 32'h30, 32'hCAFE_F00D, 32'd0, 0);
      check("sw_be", cap_be, 4'b1111);
      check("sw_wdata", cap_wdata, 32'hCAFE_F00D);

      // Load to x0 never writes back
      mem_op(mk_iw(OP_LOAD, 3'd2, 5'd0), 32'h40, 32'd0, 32'h1111_2222, 0);
      check("lw_x0_wb_en", wb_en_out, 0);
      check("lw_x0_df_en", df_mem_enable, 0);

`ifdef LSU_MISALIGN_TRAP_EN
      valid_in = 1'b1; iw_in = mk_iw(OP_LOAD, 3'd2, 5'd11); alu_in = 32'h102; wb_reg_in = 5'd11;
      tick();
      valid_in = 1'b0;
      check("mis_no_req", d_req, 0);
      check("mis_flag", lsu_misalign, 1);
      check("mis_valid", valid_out, 1);
      check("mis_wb_en", wb_en_out, 0);
      $display("misalign trap: req=%0b misalign=%0b", d_req, lsu_misalign);
      tick();
      check("mis_pulse_end", lsu_misalign, 0);
`else
      mem_op(mk_iw(OP_LOAD, 3'd2, 5'd11), 32'h102, 32'd0, 32'h0BAD_CAFE, 0);
      check("mis_req", cap_req, 1);
      check("mis_addr", cap_addr, 32'h40);
      check("mis_be", cap_be, 4'b1111);
      check("mis_data", wb_data_out, 32'h0BAD_CAFE);
      check("mis_wb_en", wb_en_out, 1);
`endif

      // Ack while idle is ignored
      tick();
      d_ack = 1'b1; d_rdata = 32'hFFFF_FFFF;
      tick();
      d_ack = 1'b0; d_rdata = 32'd0;
      check("idle_ack_valid", valid_out, 0);
      check("idle_ack_req", d_req, 0);
      check("idle_ack_stall", stall_out, 0);
      $display("idle ack: valid=%0b req=%0b", valid_out, d_req);

      // Timeout after 16 ACCESS cycles without ack
      valid_in = 1'b1; iw_in = mk_iw(OP_LOAD, 3'd2, 5'd12); alu_in = 32'h200; wb_reg_in = 5'd12;
      tick();
      for (int i = 0; i < 15; i++) tick();
      check("to_req_held", d_req, 1);
      check("to_stall_held", stall_out, 1);
      check("to_no_err_yet", lsu_err, 0);
      tick();
      valid_in = 1'b0;
      check("to_req_drop", d_req, 0);
      check("to_err", lsu_err, 1);
      check("to_valid", valid_out, 1);
      check("to_wb_en", wb_en_out, 0);
      check("to_stall", stall_out, 0);
      $display("timeout: req=%0b err=%0b valid=%0b wb_en=%0b", d_req, lsu_err, valid_out, wb_en_out);
      tick();
      check("to_err_pulse", lsu_err, 0);

      // Reset in the middle of an access, then a late ack
      valid_in = 1'b1; iw_in = mk_iw(OP_LOAD, 3'd2, 5'd13); alu_in = 32'h300; wb_reg_in = 5'd13;
      tick();
      check("ra_req", d_req, 1);
      tick();
      reset = 1'b0;
      tick();
      check("ra_req_drop", d_req, 0);
      check("ra_stall", stall_out, 0);
      check("ra_valid", valid_out, 0);
      check("ra_addr", d_addr, 0);
      check("ra_be", d_be, 0);
      check("ra_pc", pc_out, 0);
      reset = 1'b1; valid_in = 1'b0; d_ack = 1'b1; d_rdata = 32'h1234_5678;
      tick();
      d_ack = 1'b0;
      check("ra_late_ack_valid", valid_out, 0);
      check("ra_late_ack_req", d_req, 0);
      $display("reset mid-access: req=%0b valid=%0b", d_req, valid_out);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
